// File: rtl/cpu_pkg.sv
// Shared widths, reset PC and fetch entry layout for the 16-bit CPU.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FUNCT_W  = 3;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Circular buffer with push, pop, synchronous flush, occupancy count and
// combinational head read. DEPTH need not be a power of two.
module sync_fifo_flush #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign full    = (32'(count) == DEPTH);
    assign do_pop  = pop & (count != '0) & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Upstream flow control must never offer a push into a full buffer.
    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction prefetch: in-order imem requests under grant,
// PC-tagged response queue to decode, redirect flush with stale discard.
module fetch_prefetch_queue #(
    parameter  int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
    parameter  int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter  int unsigned       DEPTH    = 4,
    parameter  int unsigned       MAX_OUT  = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
    localparam int unsigned       CW       = $clog2(DEPTH) + 1,
    localparam int unsigned       OW       = $clog2(MAX_OUT) + 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [CW-1:0]      count
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     discard;
    logic [OW-1:0]     live;
    logic [ADDR_W-1:0] tag_pc;
    logic              credit;
    logic              fire;
    logic              resp_ok;
    logic              resp_keep;
    logic              pop_q;
    entry_t            q_din;
    entry_t            q_dout;

    // The tag FIFO holds one PC per request in flight, so its count is the
    // outstanding-request counter.
    assign live      = outstanding - discard;
    assign credit    = (32'(count) + 32'(live) < DEPTH) && (32'(outstanding) < MAX_OUT);
    assign imem_req  = reset & credit & ~redirect;
    assign imem_addr = fetch_pc;
    assign fire      = imem_req & imem_gnt;

    // Responses with nothing outstanding are protocol errors and ignored.
    assign resp_ok   = imem_valid & (outstanding != '0);
    assign resp_keep = resp_ok & (discard == '0) & ~redirect;

    assign instr_valid = (count != '0) & ~redirect;
    assign pop_q       = instr_valid & instr_ready;
    assign q_din       = '{instr: imem_data, pc: tag_pc};
    assign instr       = q_dout.instr;
    assign instr_pc    = q_dout.pc;

    // Fetch PC and count of in-flight responses that must be dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            discard  <= outstanding - OW'(resp_ok);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            if (resp_ok && discard != '0) begin
                discard <= discard - OW'(1);
            end
        end
    end

    // Request PCs in issue order; entries for dropped responses drain naturally.
    sync_fifo_flush #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fire),
        .din   (fetch_pc),
        .pop   (resp_ok),
        .flush (1'b0),
        .dout  (tag_pc),
        .count (outstanding)
    );

    // Instruction queue presented to decode.
    sync_fifo_flush #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk   (clk),
        .reset (reset),
        .push  (resp_keep),
        .din   (q_din),
        .pop   (pop_q),
        .flush (redirect),
        .dout  (q_dout),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order variable-latency
// instruction memory model and a PC/data scoreboard on every decode pop.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [2:0]  count;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        pending[$];
    int          cyc;
    int          lat;
    int          pops;
    int          vectors;
    int          miscompares;
    bit          chk_out;
    logic [15:0] exp_pc;

    fetch_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe at negedge, advance, then drive the memory response.
    task automatic tick();
        logic fire;
        @(negedge clk);
        fire = imem_req & imem_gnt;
        if (fire) pending.push_back('{addr: imem_addr, due: cyc + lat});
        if (imem_valid && pending.size() > 0) void'(pending.pop_front());
        if (fire && chk_out) check_val("outstanding_le_max", 32'(pending.size() <= 4), 1);
        if (instr_valid && instr_ready) begin
            check_val("pop_pc", instr_pc, exp_pc);
            check_val("pop_data", instr, mem_word(exp_pc));
            exp_pc++;
            pops++;
        end
        if (redirect) begin
            check_val("redirect_valid_low", instr_valid, 0);
            check_val("redirect_req_low", imem_req, 0);
            exp_pc = redirect_pc;
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect   = 1'b0;
        imem_valid = 1'b0;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_data  = mem_word(pending[0].addr);
        end
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        check_val(tag, instr_valid, 1);
    endtask

    task automatic startup(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) check_val({tag, "_addr0"}, imem_addr, 16'h0000);
            check_val({tag, "_count_le1"}, 32'(count <= 1), 1);
            check_val({tag, "_valid"}, instr_valid, (i >= 2) ? 1 : 0);
            tick();
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; pops = 0; cyc = 0; lat = 1; chk_out = 0;
        exp_pc = 16'h0000;
        reset = 1'b0; imem_gnt = 1'b1; imem_valid = 1'b0; imem_data = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req", imem_req, 0);
        check_val("rst_valid", instr_valid, 0);
        check_val("rst_count", count, 0);
        check_val("rst_instr", instr, 0);
        check_val("rst_instr_pc", instr_pc, 0);
        check_val("rst_addr", imem_addr, 16'h0000);
        @(posedge clk); #1; reset = 1'b1; #1;

        // Streaming, 1-cycle latency: valid from the third cycle, count <= 1
        startup("t1");

        // Decode stall: queue fills to 4 and requests stop
        instr_ready = 1'b0;
        repeat (10) tick();
        check_val("t2_count_full", count, 4);
        check_val("t2_req_off", imem_req, 0);
        check_val("t2_valid", instr_valid, 1);
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_val("t2_no_gap", instr_valid, 1);
            tick();
        end

        // 3-cycle latency: ordering and outstanding bound
        lat = 3; chk_out = 1;
        repeat (30) tick();
        // 2-cycle latency: one instruction per cycle once primed
        lat = 2;
        repeat (12) tick();
        begin
            int p0;
            p0 = pops;
            repeat (16) tick();
            check_val("t3_throughput", pops - p0, 16);
        end

        // Redirect with responses in flight and entries queued
        lat = 3;
        repeat (6) tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        check_val("t4_queued", 32'(count != 0), 1);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        check_val("t4_flushed", count, 0);
        check_val("t4_addr", imem_addr, 16'h0040);
        wait_valid("t4_first_valid");
        check_val("t4_first_pc", instr_pc, 16'h0040);
        repeat (8) tick();

        // Redirect with a response and a pop, then a second redirect
        for (int n = 0; n < 20 && !(imem_valid && instr_valid); n++) tick();
        check_val("t5_setup", imem_valid & instr_valid, 1);
        redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        check_val("t5_flushed", count, 0);
        check_val("t5_addr", imem_addr, 16'h0100);
        lat = 1;
        wait_valid("t5_first_valid");
        check_val("t5_first_pc", instr_pc, 16'h0100);
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            check_val("t5_sustained", instr_valid, 1);
            tick();
        end

        // PC wrap at 0xFFFF
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        wait_valid("t6_first_valid");
        check_val("t6_pc_fffe", instr_pc, 16'hFFFE);
        tick();
        check_val("t6_pc_ffff", instr_pc, 16'hFFFF);
        tick();
        check_val("t6_pc_0000", instr_pc, 16'h0000);
        repeat (3) tick();

        // Asynchronous reset mid-burst, then restart from RESET_PC
        reset = 1'b0; imem_valid = 1'b0; pending.delete();
        #1;
        check_val("t7_count", count, 0);
        check_val("t7_valid", instr_valid, 0);
        check_val("t7_req", imem_req, 0);
        check_val("t7_addr", imem_addr, 16'h0000);
        @(posedge clk); #1; reset = 1'b1; exp_pc = 16'h0000; #1;
        startup("t7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
